// File: rtl/dmem_mmio.sv
// Data-memory responder for a single-cycle core: word RAM with combinational read,
// plus an MMIO page holding a cycle counter, a GPIO register and a byte TX FIFO.
module dmem_mmio #(
    parameter int DEPTH_WORDS = 64,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [31:0] gpio_out,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int         IDXW      = $clog2(DEPTH_WORDS);
    localparam int         PW        = $clog2(FIFO_DEPTH);
    localparam logic [3:0] FIFO_FULL = 4'(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [31:0]     ram_q [DEPTH_WORDS];
    logic [7:0]      fifo_q [FIFO_DEPTH];

    logic [31:0]     cycle_q, cycle_d;
    logic [31:0]     gpio_q, gpio_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [3:0]      count_q, count_d;
    logic            ovf_q, ovf_d;

    logic            mmio_sel_s;
    logic [13:0]     word_off_s;
    logic [IDXW-1:0] ram_idx_s;
    logic            ram_wr_s;
    logic            gpio_wr_s;
    logic            txd_wr_s;
    logic            ovf_clr_s;
    logic            full_s;
    logic            empty_s;
    logic            pop_s;
    logic            push_s;
    logic            ovf_set_s;
    logic [31:0]     status_s;
    logic            unused_addr_s;

    // Address decode; the two byte-lane bits carry no meaning for word accesses.
    assign mmio_sel_s    = (addr[31:16] == 16'hFFFF);
    assign word_off_s    = addr[15:2];
    assign ram_idx_s     = addr[IDXW+1:2];
    assign unused_addr_s = ^addr[1:0];

    assign ram_wr_s  = memwrite && !mmio_sel_s;
    assign gpio_wr_s = memwrite && mmio_sel_s && (word_off_s == 14'd1);
    assign txd_wr_s  = memwrite && mmio_sel_s && (word_off_s == 14'd2);
    assign ovf_clr_s = memwrite && mmio_sel_s && (word_off_s == 14'd3) && writedata[8];

    assign empty_s   = (count_q == 4'd0);
    assign full_s    = (count_q == FIFO_FULL);
    assign pop_s     = !empty_s && tx_ready;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push_s    = txd_wr_s && (!full_s || pop_s);
    assign ovf_set_s = txd_wr_s && full_s && !pop_s;

    assign status_s  = {23'd0, ovf_q, count_q, 2'b00, full_s, empty_s};

    assign gpio_out  = gpio_q;
    assign tx_valid  = !empty_s;
    assign tx_data   = fifo_q[rd_ptr_q];

    // Combinational load path: RAM word or MMIO register.
    always_comb begin
        readdata = 32'd0;
        if (mmio_sel_s) begin
            case (word_off_s)
                14'd0:   readdata = cycle_q;
                14'd1:   readdata = gpio_q;
                14'd3:   readdata = status_s;
                default: readdata = 32'd0;
            endcase
        end else begin
            readdata = ram_q[ram_idx_s];
        end
    end

    // Next-state for counter, GPIO, FIFO pointers/occupancy and overflow flag.
    always_comb begin
        cycle_d  = cycle_q + 32'd1;
        gpio_d   = gpio_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (gpio_wr_s) begin
            gpio_d = writedata;
        end else begin
            gpio_d = gpio_q;
        end

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase

        // Setting beats clearing when both land in one cycle.
        if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_s) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_q  <= 32'd0;
            gpio_q   <= 32'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 4'd0;
            ovf_q    <= 1'b0;
        end else begin
            cycle_q  <= cycle_d;
            gpio_q   <= gpio_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // RAM array: contents survive reset and are undefined until written.
    always_ff @(posedge clk) begin
        if (ram_wr_s) begin
            ram_q[ram_idx_s] <= writedata;
        end
    end

    // FIFO payload storage; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_q[wr_ptr_q] <= writedata[7:0];
        end
    end
endmodule

// File: doc/dmem_mmio.md
Name: dmem_mmio

Overview:
- Data-memory responder for the single-cycle processor's data port. Services the processor's memwrite, address (ALU result), writedata and readdata interface.
- Contains a word RAM and a small memory-mapped peripheral page: cycle counter, GPIO output register, and a byte TX FIFO.
- The TX FIFO drains over a valid/ready stream to a downstream serial transmitter.
- Reads are combinational, as the single-cycle core requires. All state updates happen on the rising clock edge.

Parameters:
- DEPTH_WORDS, 64: RAM size in 32-bit words; power of 2.
- FIFO_DEPTH, 8: TX FIFO entries; power of 2, maximum 8.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low; asserted when 0.
- memwrite  in  1  write strobe from the core.
- addr  in  32  byte address (ALU result).
- writedata  in  32  store data.
- readdata  out  32  load data, combinational.
- gpio_out  out  32  GPIO register contents.
- tx_data  out  8  FIFO head byte.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  downstream accepts byte.

Behaviour:
- Decode:
  - addr[31:16]==16'hFFFF selects MMIO; anything else selects RAM.
  - addr[1:0] is ignored everywhere.
- RAM:
  - Index is addr[log2(DEPTH_WORDS)+1:2]; upper bits are ignored, so the space aliases.
  - readdata = RAM[index] combinationally.
  - On a clock edge with memwrite=1, RAM[index] <= writedata.
  - Read-during-write returns the old word in the same cycle and the new word after the edge.
  - The RAM array is not cleared by reset; its contents are undefined until written.
- MMIO map, offset addr[15:0]:
  - 0x0000 CYCLE (RO): 32-bit counter. Increments every clock while reset is deasserted; wraps 0xFFFFFFFF -> 0. Writes are ignored.
  - 0x0004 GPIO (RW): on a write, gpio_out <= writedata. Reads return gpio_out.
  - 0x0008 TXDATA (WO): a write pushes writedata[7:0]. Reads return 0.
  - 0x000C STATUS: reads return {23'b0, ovf, count[3:0], 2'b0, full, empty}. Writing with writedata[8]=1 clears ovf; all other bits are ignored.
  - Any other offset reads 0; writes are ignored.
- FIFO:
  - First-word-fall-through. tx_data = head entry; tx_valid = (count!=0).
  - Pop occurs when tx_valid && tx_ready at the edge.
  - Push occurs on a TXDATA write when not full, or when full with a pop in the same cycle. In the full-with-pop case the push is accepted and count is unchanged.
  - A push while full with no pop drops the byte and sets ovf (sticky).
  - If ovf set and ovf clear coincide, set wins.
  - Push and pop in the same cycle with count in 1..FIFO_DEPTH-1: count is unchanged, order is preserved.
  - Push into an empty FIFO: tx_valid rises the cycle after the edge. There is no bypass to tx_data in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH; full = (count==FIFO_DEPTH).
  - tx_data when empty is don't-care; the bench must not check it.
- Reset (async assert, regardless of clk):
  - CYCLE=0, gpio_out=0, FIFO pointers and count=0, ovf=0, tx_valid=0.
  - readdata keeps following addr combinationally.
  - Reset asserted mid-drain discards all queued bytes; a handshake in flight is lost.
  - After deassert, CYCLE reads 1 following the first edge.
- Stream rules: tx_data must be held stable while tx_valid=1 and tx_ready=0.

Test Plan:
- RAM: write 0xDEADBEEF @0x10, then 0x12345678 @0x10+4*DEPTH_WORDS. Required: read @0x10 = 0x12345678 (aliasing); read @0x14 = its own written value.
- GPIO/CYCLE: write 0xA5A5A5A5 to 0xFFFF0004. Required: gpio_out=0xA5A5A5A5 next cycle. Read CYCLE N edges after reset release. Required: value = N.
- FIFO fill: tx_ready=0; push 0x01..0x09 (9 bytes). Required: STATUS = 0x00000182 (ovf=1, count=8, full=1); tx_data=0x01. Then write 0x100 to STATUS. Required: ovf=0.
- Drain: from full, tx_ready=1 while pushing 0x55 every cycle. Required: count stays 8, ovf stays 0; output order 0x01..0x08 followed by 0x55s.
- Empty push: push 0x7E into an empty FIFO. Required: tx_valid=0 in the push cycle, 1 the next cycle, tx_data=0x7E. With tx_ready=1, tx_valid drops one cycle later.
- Reset: assert reset with 3 bytes queued and tx_ready=0, mid-cycle (asynchronously). Required: tx_valid=0, STATUS=0x1, gpio_out=0, CYCLE=0 immediately.
